// File: rtl/pp_pkg.sv
// Shared types and packed-field helpers for the post-processing stage sequencer.
package pp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } pp_seq_state_t;

  // is_real marks a genuine pixel; flush bubbles carry is_real=0 and no tags.
  typedef struct packed {
    logic is_real;
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } pp_tag_t;

  // Each direction field is DWIDTH+2 bits, packed {135, 90, 45} with 45 in the LSBs.
  function automatic int unsigned pp_field_w(input int unsigned dwidth);
    return dwidth + 2;
  endfunction

  function automatic int unsigned pp_off_45(input int unsigned dwidth);
    return 0 * (dwidth + 2);
  endfunction

  function automatic int unsigned pp_off_90(input int unsigned dwidth);
    return 1 * (dwidth + 2);
  endfunction

  function automatic int unsigned pp_off_135(input int unsigned dwidth);
    return 2 * (dwidth + 2);
  endfunction

endpackage

// File: rtl/pp_stage_sequencer_tag_pipe.sv
// Shadow tag shift register that tracks the register chain's valid path.
module pp_tag_pipe
  import pp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    shift,
  input  logic    clr,
  input  pp_tag_t tag_in,
  output pp_tag_t tag_out
);

  pp_tag_t [DEPTH-1:0] stage_d, stage_q;

  // Next stage contents: clear wins over shift, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (clr) begin
      stage_d = '0;
    end else if (shift) begin
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/pp_stage_sequencer.sv
// Frame/line sequencer driving the post-processing register chain.
module pp_stage_sequencer
  import pp_pkg::*;
#(
  parameter int unsigned DWIDTH     = 7,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3*DWIDTH+6-1:0]      in_data,
  input  logic                       out_ready,
  output logic                       pp_clken,
  output logic                       pp_enable,
  output logic [3*DWIDTH+6-1:0]      pp_din,
  output logic                       tag_valid,
  output logic                       tag_sol,
  output logic                       tag_eol,
  output logic                       tag_sof,
  output logic                       tag_eof,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned FW = $clog2(PIPE_DEPTH + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(PIPE_DEPTH - 1);

  pp_seq_state_t state_d, state_q;
  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic [FW-1:0] flush_d, flush_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          adv;
  pp_tag_t       tag_in, tag_out;

  // Chain handshake and data mux; combinational so the chain sees them in-cycle.
  always_comb begin
    in_ready  = 1'b0;
    pp_clken  = 1'b0;
    pp_enable = 1'b0;
    pp_din    = '0;
    tag_in    = '0;
    case (state_q)
      ST_RUN: begin
        in_ready       = out_ready;
        pp_clken       = out_ready;
        pp_enable      = in_valid;
        pp_din         = in_data;
        tag_in.is_real = 1'b1;
        tag_in.sol     = (col_q == '0);
        tag_in.eol     = (col_q == COL_LAST);
        tag_in.sof     = (col_q == '0) && (row_q == '0);
        tag_in.eof     = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
      ST_FLUSH: begin
        pp_clken  = out_ready;
        pp_enable = 1'b1;
      end
      default: ;
    endcase
    adv = pp_clken & pp_enable;
  end

  // Next state, position counters and flush counter. RUN/FLUSH only move on adv,
  // which already folds in out_ready; DONE always drops back so the pulse stays one cycle.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    flush_d = flush_q;
    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
      flush_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
          end
        end
        ST_RUN: begin
          if (adv) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = ST_FLUSH;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (adv) begin
            if (flush_q == FL_LAST) begin
              flush_d = '0;
              state_d = ST_DONE;
            end else begin
              flush_d = flush_q + 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  pp_tag_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .shift  (adv),
    .clr    (abort),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign tag_valid  = tag_out.is_real;
  assign tag_sol    = tag_out.sol;
  assign tag_eol    = tag_out.eol;
  assign tag_sof    = tag_out.sof;
  assign tag_eof    = tag_out.eof;
  assign col        = col_q;
  assign row        = row_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/pp_stage_sequencer.md
# pp_stage_sequencer

Frame/line sequencer for the post-processing register chain. It accepts the packed 45°/90°/135° aggregated-cost stream from upstream and drives the chain's `clken`, `enable` and `din`. It tracks column and row position, and flushes the chain's two-stage valid pipeline at end of frame. A shadow tag pipeline carries real/flush markers and `sol`/`eol`/`sof`/`eof` so tags leave aligned with the chain's valid output.

## Interface
- `DWIDTH`, 7: per-direction cost width minus 2; each direction field is `DWIDTH+2` bits.
- `IMG_W`, 640: pixels per line.
- `IMG_H`, 480: lines per frame.
- `PIPE_DEPTH`, 2: enabled-cycle depth of the register chain's valid path.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a frame. Only honoured in IDLE.
- `abort` in 1: synchronous return to IDLE from any state.
- `in_valid` in 1: upstream data valid.
- `in_ready` out 1: upstream handshake.
- `in_data` in `3*DWIDTH+6`: packed as {135, 90, 45}, with 45 in the LSBs.
- `out_ready` in 1: downstream can accept; gates the whole chain.
- `pp_clken` out 1: to the chain's `clken`.
- `pp_enable` out 1: to the chain's `enable`.
- `pp_din` out `3*DWIDTH+6`: to the chain's `din`.
- `tag_valid` out 1: the chain output word is a real pixel, not a flush bubble.
- `tag_sol`, `tag_eol`, `tag_sof`, `tag_eof` out 1 each: position tags aligned with `tag_valid`.
- `col` out `$clog2(IMG_W)`: input-side column counter.
- `row` out `$clog2(IMG_H)`: input-side row counter.
- `busy` out 1: high when state is not IDLE.
- `frame_done` out 1: one-cycle pulse.

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset enters IDLE.
- Reset values: all outputs 0, `col`/`row` 0, flush counter 0, tag pipe cleared.
- Define `adv = pp_clken & pp_enable`. The chain and the tag pipe shift only on `adv`.
- IDLE:
  - `in_ready=0`, `pp_clken=0`, `pp_enable=0`.
  - `start` → RUN, with `col=row=0`.
- RUN:
  - `pp_clken=out_ready`, `pp_enable=in_valid`, `in_ready=out_ready`, `pp_din=in_data`.
  - Each accepted pixel (`in_valid & in_ready`) increments `col`.
  - When `col==IMG_W-1`, `col` wraps to 0 and `row` increments.
  - Accepting pixel (`IMG_W-1`, `IMG_H-1`) → FLUSH; `row` wraps to 0.
- Tags entering the pipe on an accepted pixel:
  - real=1.
  - `sol = (col==0)`.
  - `eol = (col==IMG_W-1)`.
  - `sof = (col==0 & row==0)`.
  - `eof = (col==IMG_W-1 & row==IMG_H-1)`.
- FLUSH:
  - `in_ready=0`, `pp_enable=1`, `pp_clken=out_ready`, `pp_din=0`.
  - Flush entries enter the tag pipe with real=0 and all tags 0.
  - After `PIPE_DEPTH` flush `adv` cycles → DONE.
- DONE: `frame_done=1` for one cycle → IDLE.
- Tag outputs are the last tag-pipe stage. `tag_valid = stage_real`, so flush bubbles are never marked valid even though the chain's own valid reads 1.
- Simultaneous events:
  - `abort` beats `start`.
  - `abort` in any state → IDLE next cycle; counters and tag pipe are cleared.
  - `start` outside IDLE is ignored.
- `out_ready=0` freezes everything: counters, flush counter, tag pipe and state, except `abort`.

## Timing
- Fully synchronous except `rst`. `in_ready`, `pp_clken` and `pp_enable` are combinational from state, `out_ready` and `in_valid`. The chain's register timing is built on them, so they are not registered.
- Pixel latency: a pixel accepted on `adv` cycle k has `tag_valid` and its tags high after `adv` cycle k+`PIPE_DEPTH-1`. This matches the chain's valid output.
- Frame: `IMG_W*IMG_H` accepts + `PIPE_DEPTH` flush advances. `frame_done` asserts the cycle after the last flush advance.
- With `out_ready=1` and no gaps, the frame takes `IMG_W*IMG_H + PIPE_DEPTH + 1` cycles from the first accept through DONE.
- `rst` asserted mid-frame: immediate clear; no `frame_done` pulse.

## Structure
- Package `pp_pkg`:
  - state enum `pp_seq_state_t`.
  - tag struct `pp_tag_t` {real, sol, eol, sof, eof}.
  - packed-field offset constants for the 45/90/135 slices, derived from `DWIDTH`.
- Sub-module `pp_tag_pipe`: a `PIPE_DEPTH`-deep shift register of `pp_tag_t`, with shift enable, synchronous clear and asynchronous active-low reset.
- The top level holds the FSM, the counters and the flush counter.

## Test plan
Test parameters: `IMG_W=4`, `IMG_H=2`, `PIPE_DEPTH=2`.
- Reset during RUN at `col=2`: all outputs 0, state IDLE. A later `start` restarts at `col=0`, `row=0`.
- Continuous frame, 8 pixels with `in_data`=1..8:
  - `tag_valid` sequence shows 8 ones, then flush entries with `tag_valid=0`.
  - `tag_sof` is on pixel 1, `tag_eol` on pixels 4 and 8, `tag_eof` on pixel 8.
  - `frame_done` fires at cycle 11 after the first accept.
- Hold `out_ready=0` for 3 cycles mid-line: `pp_clken=0`, and `col`, `row` and the tags stay frozen. The pixel order at the output is unchanged.
- Drive `in_valid=0` gaps: `pp_enable=0` and the tag pipe does not shift. The counters advance only on accepts.
- Assert `abort` and `start` together during FLUSH: IDLE next cycle, `busy=0`, no `frame_done`, tag pipe cleared.
- `start` pulse during RUN: ignored, and the counters continue normally.
